// File: rtl/fifo_rd_framer_pkg.sv
// Shared state encoding and header layout for the FIFO read-side frame drainer.
package fifo_rd_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_COMMIT,
    ST_REPLAY
  } state_t;

  localparam int HDR_LEN_LSB = 0;
  localparam int STAT_W      = 16;

  // The length field is one bit wider than the FIFO address, so it can carry a full-FIFO count.
  function automatic int hdr_len_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer with same-cycle bypass when empty: zero latency, holds up to two words
// while i_rdy is low. The producer must watch o_cnt so that it never pushes into a full buffer.
module fifo_rd_skid #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_rdy,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat,
  output logic [1:0]       o_cnt
);

  logic [WIDTH-1:0] r_dat0;
  logic [WIDTH-1:0] r_dat1;
  logic [1:0]       r_cnt;
  logic             w_pop;

  assign o_vld = i_vld || (r_cnt != 2'd0);
  assign o_dat = (r_cnt != 2'd0) ? r_dat0 : i_dat;
  assign o_cnt = r_cnt;
  assign w_pop = o_vld && i_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= 2'd0;
      r_dat0 <= '0;
      r_dat1 <= '0;
    end else if (i_clr) begin
      r_cnt <= 2'd0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (i_vld && !w_pop) begin
            r_dat0 <= i_dat;
            r_cnt  <= 2'd1;
          end
        end
        2'd1: begin
          if (i_vld && w_pop) begin
            r_dat0 <= i_dat;
          end else if (i_vld) begin
            r_dat1 <= i_dat;
            r_cnt  <= 2'd2;
          end else if (w_pop) begin
            r_cnt <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_dat0 <= r_dat1;
            if (i_vld) r_dat1 <= i_dat;
            else       r_cnt  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_framer.sv
// Drains length-prefixed frames from async_fifo onto a valid/ready stream. It snapshots the FIFO read
// address on commit and rolls it back on abort. First beat 3 cycles after header read. Optional stats: RD_FRAMER_STATS_EN.
module fifo_rd_framer
  import fifo_rd_framer_pkg::*;
#(
  parameter int ADDR    = 4,
  parameter int WIDTH   = 32,
  parameter int MAX_LEN = 15
) (
  input  logic              rdclk,
  input  logic              rst_rdclk,
  input  logic              sw_flush,
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  read_data,
  output logic              read_en,
  output logic              snap_rdaddr,
  output logic              roll_rdaddr,
  output logic              rst_rdaddr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  input  logic              out_abort,
  output logic              frame_done,
  output logic              hdr_err,
  output logic [STAT_W-1:0] frame_cnt,
  output logic [STAT_W-1:0] abort_cnt
);

  localparam int LW = hdr_len_w(ADDR);

  state_t          r_state;
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   r_rd_left;
  logic [LW-1:0]   r_beats;
  logic            r_inflight;
  logic            r_snap;
  logic            r_done;
  logic            r_hdr_err;

  logic [LW-1:0]   w_hdr_len;
  logic            w_hdr_legal;
  logic            w_active;
  logic            w_abort;
  logic            w_read_en;
  logic            w_skid_vld;
  logic [WIDTH-1:0] w_skid_dat;
  logic [1:0]      w_skid_cnt;
  logic [2:0]      w_occ;
  logic            w_acc;
  logic            w_last;

  assign w_hdr_len   = read_data[HDR_LEN_LSB +: LW];
  assign w_hdr_legal = (w_hdr_len != '0) && (w_hdr_len <= LW'(MAX_LEN));
  assign w_active    = (r_state == ST_HDR) || (r_state == ST_PAYLOAD);
  assign w_abort     = w_active && out_abort && !sw_flush;
  assign w_occ       = {1'b0, w_skid_cnt} + {2'b00, r_inflight};

  // Reads are throttled so buffered plus in-flight words never exceed the two skid slots.
  always_comb begin
    w_read_en = 1'b0;
    if (!rst_rdclk && !sw_flush && !fifo_empty) begin
      if (r_state == ST_IDLE)
        w_read_en = 1'b1;
      else if (r_state == ST_PAYLOAD)
        w_read_en = !out_abort && (r_rd_left != '0) && (w_occ < 3'd2);
    end
  end

  fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
    .i_clk (rdclk),
    .i_rst (rst_rdclk),
    .i_clr (sw_flush || w_abort),
    .i_vld (r_inflight && (r_state == ST_PAYLOAD)),
    .i_dat (read_data),
    .i_rdy (out_ready),
    .o_vld (w_skid_vld),
    .o_dat (w_skid_dat),
    .o_cnt (w_skid_cnt)
  );

  assign out_valid   = w_skid_vld && !rst_rdclk;
  assign out_data    = out_valid ? w_skid_dat : '0;
  assign w_last      = out_valid && (r_beats == (r_len - LW'(1)));
  assign out_last    = w_last;
  assign w_acc       = out_valid && out_ready;
  assign read_en     = w_read_en;
  assign roll_rdaddr = w_abort && !rst_rdclk;
  assign rst_rdaddr  = sw_flush && !rst_rdclk;
  assign snap_rdaddr = r_snap;
  assign frame_done  = r_done;
  assign hdr_err     = r_hdr_err;

  always_ff @(posedge rdclk or posedge rst_rdclk) begin
    if (rst_rdclk) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_rd_left  <= '0;
      r_beats    <= '0;
      r_inflight <= 1'b0;
      r_snap     <= 1'b0;
      r_done     <= 1'b0;
      r_hdr_err  <= 1'b0;
    end else begin
      r_inflight <= w_read_en;
      r_snap     <= 1'b0;
      r_done     <= 1'b0;
      r_hdr_err  <= 1'b0;
      if (sw_flush) begin
        r_state   <= ST_IDLE;
        r_len     <= '0;
        r_rd_left <= '0;
        r_beats   <= '0;
      end else if (w_abort) begin
        r_state <= ST_REPLAY;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_read_en) r_state <= ST_HDR;
          end
          ST_HDR: begin
            if (w_hdr_legal) begin
              r_len     <= w_hdr_len;
              r_rd_left <= w_hdr_len;
              r_beats   <= '0;
              r_state   <= ST_PAYLOAD;
            end else begin
              // A bad header is committed past so the writer can reclaim its slot.
              r_hdr_err <= 1'b1;
              r_snap    <= 1'b1;
              r_state   <= ST_COMMIT;
            end
          end
          ST_PAYLOAD: begin
            if (w_read_en) r_rd_left <= r_rd_left - LW'(1);
            if (w_acc) begin
              r_beats <= r_beats + LW'(1);
              if (w_last) begin
                r_snap  <= 1'b1;
                r_done  <= 1'b1;
                r_state <= ST_COMMIT;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef RD_FRAMER_STATS_EN
  logic [STAT_W-1:0] r_frame_cnt;
  logic [STAT_W-1:0] r_abort_cnt;

  always_ff @(posedge rdclk or posedge rst_rdclk) begin
    if (rst_rdclk) begin
      r_frame_cnt <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (r_done && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + STAT_W'(1);
      if (w_abort && (r_abort_cnt != '1)) r_abort_cnt <= r_abort_cnt + STAT_W'(1);
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign abort_cnt = r_abort_cnt;
`else
  assign frame_cnt = '0;
  assign abort_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Directed bench for fifo_rd_framer with a small behavioural FIFO model on the read side.
module tb_fifo_rd_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw_flush;
  logic        fifo_empty;
  logic [31:0] read_data;
  logic        read_en;
  logic        snap_rdaddr;
  logic        roll_rdaddr;
  logic        rst_rdaddr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_abort;
  logic        frame_done;
  logic        hdr_err;
  logic [15:0] frame_cnt;
  logic [15:0] abort_cnt;

`ifdef RD_FRAMER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  fifo_rd_framer #(.ADDR(4), .WIDTH(32), .MAX_LEN(15)) dut (
    .rdclk       (clk),
    .rst_rdclk   (rst),
    .sw_flush    (sw_flush),
    .fifo_empty  (fifo_empty),
    .read_data   (read_data),
    .read_en     (read_en),
    .snap_rdaddr (snap_rdaddr),
    .roll_rdaddr (roll_rdaddr),
    .rst_rdaddr  (rst_rdaddr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_abort   (out_abort),
    .frame_done  (frame_done),
    .hdr_err     (hdr_err),
    .frame_cnt   (frame_cnt),
    .abort_cnt   (abort_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: 1-cycle read latency, committed-address snapshot, rollback and flush.
  logic [31:0] mem [256];
  int wrp = 0;
  int rdp = 0;
  int snp = 0;

  assign fifo_empty = (rdp == wrp);

  always @(posedge clk) begin
    if (rst) begin
      rdp       <= wrp;
      snp       <= wrp;
      read_data <= '0;
    end else begin
      if (rst_rdaddr) begin
        rdp <= wrp;
        snp <= wrp;
      end else if (roll_rdaddr) begin
        rdp <= snp;
      end else if (read_en) begin
        read_data <= mem[rdp[7:0]];
        rdp       <= rdp + 1;
      end
      if (snap_rdaddr) snp <= rdp;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] q_dat [$];
  bit          q_last[$];
  int          q_cyc [$];
  int vld_n = 0, rd_n = 0, snap_n = 0, done_n = 0, err_n = 0, roll_n = 0, rsta_n = 0;
  int snap_cyc = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready && !out_abort) begin
      q_dat.push_back(out_data);
      q_last.push_back(out_last);
      q_cyc.push_back(cyc);
    end
    if (out_valid)   vld_n++;
    if (read_en)     rd_n++;
    if (snap_rdaddr) begin snap_n++; snap_cyc = cyc; end
    if (frame_done)  done_n++;
    if (hdr_err)     err_n++;
    if (roll_rdaddr) roll_n++;
    if (rst_rdaddr)  rsta_n++;
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wrp[7:0]] = w;
    wrp++;
  endtask

  task automatic wait_done(input string tag, input int base, input int limit);
    int n = 0;
    while (done_n == base && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(done_n != base), 64'd1);
  endtask

  task automatic wait_vld(input string tag, input int limit);
    int n = 0;
    while (!out_valid && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(out_valid), 64'd1);
  endtask

  initial begin
    int qb, db, sb, eb, vb, rb, rlb, rab, t0, t1, n;

    rst = 1'b1; sw_flush = 1'b0; out_ready = 1'b0; out_abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 64'({read_en, out_valid, out_last, snap_rdaddr, roll_rdaddr,
                         rst_rdaddr, frame_done, hdr_err}), 64'd0);
    chk("rst_cnts", 64'({frame_cnt, abort_cnt}), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", 64'({read_en, out_valid, snap_rdaddr, out_data}), 64'd0);

    // 1: len 3 at full rate
    @(posedge clk); #1;
    out_ready = 1'b1;
    qb = q_dat.size(); db = done_n;
    push(32'h0000_0003); push(32'hA0A0_0001); push(32'hA0A0_0002); push(32'hA0A0_0003);
    t0 = -100;
    for (int i = 0; i < 20 && t0 < 0; i++) begin
      @(negedge clk);
      if (read_en) t0 = cyc;
    end
    t1 = -1;
    for (int i = 0; i < 20 && t1 < 0; i++) begin
      @(negedge clk);
      if (out_valid) t1 = cyc;
    end
    chk("t1_latency", 64'(t1 - t0), 64'd3);
    wait_done("t1_done", db, 40);
    chk("t1_nbeats", 64'(q_dat.size() - qb), 64'd3);
    chk("t1_beats", {q_dat[qb], q_dat[qb+2]}, {32'hA0A0_0001, 32'hA0A0_0003});
    chk("t1_beat_b", 64'(q_dat[qb+1]), 64'hA0A0_0002);
    chk("t1_last", 64'({q_last[qb], q_last[qb+1], q_last[qb+2]}), 64'b001);
    chk("t1_rate", 64'(q_cyc[qb+2] - q_cyc[qb]), 64'd2);
    chk("t1_snap_lag", 64'(snap_cyc - q_cyc[qb+2]), 64'd1);
    chk("t1_ndone", 64'(done_n - db), 64'd1);

    // 2: same frame, 5-cycle stall after beat A
    qb = q_dat.size(); db = done_n;
    push(32'h0000_0003); push(32'hB0B0_0001); push(32'hB0B0_0002); push(32'hB0B0_0003);
    n = 0;
    while (q_dat.size() == qb && n < 30) begin @(posedge clk); #1; n++; end
    out_ready = 1'b0;
    rb = rd_n;
    @(negedge clk); @(negedge clk);
    chk("t2_hold_a", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'hB0B0_0002});
    repeat (3) @(negedge clk);
    chk("t2_hold_b", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'hB0B0_0002});
    chk("t2_stall_reads", 64'(rd_n - rb), 64'd1);
    @(posedge clk); #1; out_ready = 1'b1;
    wait_done("t2_done", db, 40);
    chk("t2_nbeats", 64'(q_dat.size() - qb), 64'd3);
    chk("t2_order", {q_dat[qb+1], q_dat[qb+2]}, {32'hB0B0_0002, 32'hB0B0_0003});
    chk("t2_last", 64'({q_last[qb], q_last[qb+1], q_last[qb+2]}), 64'b001);

    // 3: len 4, abort after two beats, full replay
    qb = q_dat.size(); db = done_n; rlb = roll_n;
    push(32'h0000_0004);
    for (int i = 0; i < 4; i++) push(32'hC0C0_0000 + 32'(i));
    n = 0;
    while (q_dat.size() < qb + 2 && n < 30) begin @(posedge clk); #1; n++; end
    out_abort = 1'b1;
    @(negedge clk);
    chk("t3_roll", 64'({roll_rdaddr, read_en}), 64'b10);
    @(posedge clk); #1; out_abort = 1'b0;
    @(negedge clk);
    chk("t3_vld_drop", 64'(out_valid), 64'd0);
    wait_done("t3_done", db, 60);
    chk("t3_nbeats", 64'(q_dat.size() - qb), 64'd6);
    chk("t3_pre", {q_dat[qb], q_dat[qb+1]}, {32'hC0C0_0000, 32'hC0C0_0001});
    chk("t3_replay_a", {q_dat[qb+2], q_dat[qb+3]}, {32'hC0C0_0000, 32'hC0C0_0001});
    chk("t3_replay_b", {q_dat[qb+4], q_dat[qb+5]}, {32'hC0C0_0002, 32'hC0C0_0003});
    chk("t3_last", 64'({q_last[qb], q_last[qb+1], q_last[qb+2], q_last[qb+3],
                        q_last[qb+4], q_last[qb+5]}), 64'b000001);
    chk("t3_nroll", 64'(roll_n - rlb), 64'd1);
    chk("t3_abort_cnt", 64'(abort_cnt), STATS ? 64'd1 : 64'd0);
    chk("t3_frame_cnt", 64'(frame_cnt), STATS ? 64'd3 : 64'd0);

    // 4: len 0 and len MAX_LEN+1 are dropped
    db = done_n; sb = snap_n; eb = err_n; vb = vld_n;
    push(32'h0000_0000); push(32'h0000_0010);
    repeat (15) begin @(posedge clk); #1; end
    chk("t4_hdr_err", 64'(err_n - eb), 64'd2);
    chk("t4_snap", 64'(snap_n - sb), 64'd2);
    chk("t4_no_done", 64'(done_n - db), 64'd0);
    chk("t4_no_vld", 64'(vld_n - vb), 64'd0);

    // 5: len 2, FIFO runs dry after the first payload word
    qb = q_dat.size(); db = done_n;
    push(32'h0000_0002); push(32'hD0D0_0001);
    repeat (12) begin @(posedge clk); #1; end
    chk("t5_one_beat", 64'(q_dat.size() - qb), 64'd1);
    chk("t5_idle_outs", 64'({out_valid, read_en}), 64'd0);
    chk("t5_no_done", 64'(done_n - db), 64'd0);
    push(32'hD0D0_0002);
    wait_done("t5_done", db, 20);
    chk("t5_beats", {q_dat[qb], q_dat[qb+1]}, {32'hD0D0_0001, 32'hD0D0_0002});
    chk("t5_last", 64'({q_last[qb], q_last[qb+1]}), 64'b01);

    // 6a: asynchronous reset while a frame is stalled in PAYLOAD
    out_ready = 1'b0;
    push(32'h0000_0003); push(32'hE0E0_0001); push(32'hE0E0_0002); push(32'hE0E0_0003);
    wait_vld("t6_vld_pre", 30);
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_frame_cnt_pre", 64'(frame_cnt), STATS ? 64'd4 : 64'd0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_arst_outs", 64'({read_en, out_valid, out_last, snap_rdaddr, roll_rdaddr,
                             rst_rdaddr, frame_done, hdr_err}), 64'd0);
    chk("t6_arst_data", 64'(out_data), 64'd0);
    chk("t6_arst_cnts", 64'({frame_cnt, abort_cnt}), 64'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;

    // 6b: soft flush mid-frame, then a clean frame
    push(32'h0000_0003); push(32'hF0F0_0001); push(32'hF0F0_0002); push(32'hF0F0_0003);
    wait_vld("t6_vld_flush", 30);
    repeat (3) begin @(posedge clk); #1; end
    sb = snap_n; rab = rsta_n; db = done_n;
    sw_flush = 1'b1;
    @(negedge clk);
    chk("t6_flush_pulse", 64'({rst_rdaddr, snap_rdaddr}), 64'b10);
    @(posedge clk); #1; sw_flush = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("t6_flush_nrst", 64'(rsta_n - rab), 64'd1);
    chk("t6_flush_nosnap", 64'({snap_n - sb, done_n - db}), 64'd0);
    chk("t6_flush_idle", 64'({out_valid, read_en}), 64'd0);
    out_ready = 1'b1;
    qb = q_dat.size(); db = done_n;
    push(32'h0000_0001); push(32'h1234_5678);
    wait_done("t6_recover_done", db, 20);
    chk("t6_recover_beat", {31'd0, q_last[qb], q_dat[qb]}, {31'd0, 1'b1, 32'h1234_5678});
    chk("t6_frame_cnt", 64'(frame_cnt), STATS ? 64'd1 : 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
